alu_operand_seq: RTL
====================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_data, input, 4 bits: operand/select nibble stream.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a beat.
REQ-006 SHALL have port abort, input, 1 bit: synchronous discard of the current operation.
REQ-007 SHALL have ports alu_a, alu_b, alu_s, outputs, 4 bits each: registered operands A, B, S driven to the downstream combinational ALU.
REQ-008 SHALL have port alu_e, input, 4 bits: combinational ALU result E.
REQ-009 SHALL have port res, output, 4 bits: captured result.
REQ-010 SHALL have port res_valid, output, 1 bit: res valid.
REQ-011 SHALL have port res_ready, input, 1 bit: consumer accepts res.
REQ-012 SHALL have port op_count, output, 8 bits: completed-operation counter.

Function
REQ-013 SHALL accept a beat when in_valid and in_ready are both 1 at a rising edge.
REQ-014 SHALL implement FSM states LOAD_A, LOAD_B, LOAD_S, EXEC and HOLD.
REQ-015 SHALL drive in_ready = 1 only in LOAD_A, LOAD_B and LOAD_S, and SHALL drive in_ready = 0 in EXEC, in HOLD and while rst = 1.
REQ-016 SHALL, on an accepted beat in LOAD_A, LOAD_B or LOAD_S, load in_data into alu_a, alu_b or alu_s respectively and advance to LOAD_B, LOAD_S or EXEC respectively; without an accepted beat, state and registers SHALL hold.
REQ-017 SHALL, in EXEC (exactly one cycle), register alu_e into res, set res_valid = 1 and go to HOLD.
REQ-018 SHALL give a latency of 2 edges: S beat accepted at edge n, res valid after edge n+1.
REQ-019 SHALL hold alu_a, alu_b and alu_s stable from S acceptance until the next accepted A beat.
REQ-020 SHALL, in HOLD, keep res and res_valid stable until res_ready = 1; on that edge it SHALL clear res_valid, increment op_count and go to LOAD_A.
REQ-021 SHALL increment op_count modulo 256 (255 -> 0), with no other side effect.
REQ-022 SHALL, when abort = 1 in any state, go to LOAD_A at the next edge, clear res_valid and not increment op_count; abort SHALL win over a simultaneous beat or res handshake.
REQ-023 SHALL leave alu_a, alu_b, alu_s and res unchanged on abort; they are overwritten by subsequent loads.
REQ-024 SHALL ignore in_valid while in_ready = 0, with no buffering of ignored beats.
REQ-025 SHALL NOT accept new operand beats in the HOLD cycle in which the res handshake completes; the first new A beat is accepted one edge later.

Reset
REQ-026 SHALL, on rst = 1 regardless of clk, immediately force state to LOAD_A, alu_a, alu_b, alu_s and res to 4'b0000, res_valid to 0 and op_count to 8'h00.
REQ-027 SHALL reset mid-operation by discarding partial operands and any pending result with no handshake.
REQ-028 SHALL, after rst deasserts, accept an A beat at the first rising edge with in_valid = 1.

Verification
REQ-029 SHALL pass this test, with the bench instantiating the 4-bit ALU on alu_a/alu_b/alu_s/alu_e: beats 1100, 1010, 1100 with res_ready = 1 -> res = 0011 with res_valid high for exactly 1 cycle and op_count = 1.
REQ-030 SHALL pass this test: beats 1111, 0101, 1000 with res_ready held 0 for 5 cycles -> res = 1010 stable, res_valid = 1 and in_ready = 0 throughout; release -> LOAD_A and op_count + 1.
REQ-031 SHALL pass this test: S = 0000 with any A/B -> res = 1111; beats arriving with idle gaps (in_valid toggling) -> same result, latency measured from S acceptance = 2 edges.
REQ-032 SHALL pass this test: abort after the B beat, then beats 0011, 0001, 0100 -> res = 1101 (A&~B = 0010, inverted), op_count not incremented by the aborted operation.
REQ-033 SHALL pass this test: rst pulsed asynchronously (between edges) while in HOLD -> outputs 0 immediately, res_valid = 0, in_ready = 0 during rst and 1 after release.
REQ-034 SHALL pass this test: 256 back-to-back operations -> op_count wraps to 0; abort coincident with res_ready = 1 -> no increment, state LOAD_A.

Source files
------------

// File: rtl/alu_operand_seq.sv
// Operand sequencer for a downstream combinational 4-bit ALU: collects A, B and S
// nibbles, captures the ALU result and holds it until the consumer takes it.
module alu_operand_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_s,
   input  logic [3:0] alu_e,
   output logic [3:0] res,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] op_count
);

   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B = 3'd1,
      LOAD_S = 3'd2,
      EXEC   = 3'd3,
      HOLD   = 3'd4
   } state_t;

   state_t     state_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [3:0] s_q;
   logic [3:0] res_q;
   logic       res_valid_q;
   logic [7:0] op_count_q;
   logic [7:0] op_count_d;
   logic       load_state;
   logic       accept;

   assign load_state = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_S);
   // Reset forces LOAD_A, so rst is folded in to keep in_ready low while it is held.
   assign in_ready   = load_state && !rst;
   assign accept     = in_valid && in_ready;
   assign op_count_d = op_count_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD_A;
         a_q         <= 4'b0000;
         b_q         <= 4'b0000;
         s_q         <= 4'b0000;
         res_q       <= 4'b0000;
         res_valid_q <= 1'b0;
         op_count_q  <= 8'h00;
      end else if (abort) begin
         // Operands and res are left as-is; later loads overwrite them.
         state_q     <= LOAD_A;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: if (accept) begin
               a_q     <= in_data;
               state_q <= LOAD_B;
            end
            LOAD_B: if (accept) begin
               b_q     <= in_data;
               state_q <= LOAD_S;
            end
            LOAD_S: if (accept) begin
               s_q     <= in_data;
               state_q <= EXEC;
            end
            EXEC: begin
               res_q       <= alu_e;
               res_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: if (res_ready) begin
               res_valid_q <= 1'b0;
               op_count_q  <= op_count_d;
               state_q     <= LOAD_A;
            end
            default: state_q <= LOAD_A;
         endcase
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_s     = s_q;
   assign res       = res_q;
   assign res_valid = res_valid_q;
   assign op_count  = op_count_q;

endmodule
